// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and constants for the interrupt controller
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    // Each vector entry holds a 32-bit handler PC as two 16-bit words
    localparam int VEC_ENTRY_WORDS = 2;

    // Id width for n channels, never narrower than one bit
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// rtl/irq_controller_if.sv - request/acknowledge link between controller and pipeline
interface irq_controller_if #(
    parameter int NUM_IRQ = 4
);
    localparam int ID_W = irq_pkg::clog2_min1(NUM_IRQ);

    logic            int_req;
    logic            int_ack;
    logic            rti;
    logic            in_service;
    logic [ID_W-1:0] int_id;
    logic [15:0]     vec_addr;

    modport master (
        output int_req, int_id, vec_addr, in_service,
        input  int_ack, rti
    );

    modport slave (
        input  int_req, int_id, vec_addr, in_service,
        output int_ack, rti
    );
endinterface

// File: rtl/irq_priority_enc.sv
// rtl/irq_priority_enc.sv - fixed priority encoder, lowest set bit wins
module irq_priority_enc
    import irq_pkg::*;
#(
    parameter int  NUM_IRQ = 4,
    localparam int ID_W    = clog2_min1(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] eligible,
    output logic               found,
    output logic [ID_W-1:0]    id
);

    // Scan from the top so the lowest set index is the last one written
    always_comb begin
        found = 1'b0;
        id    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                found = 1'b1;
                id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - multi-channel interrupt controller with single in-service tracking
module irq_controller
    import irq_pkg::*;
#(
    parameter int                 NUM_IRQ   = 4,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = {NUM_IRQ{1'b1}},
    parameter logic [15:0]        VEC_BASE  = 16'h0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] mask,
    irq_controller_if.master   bus
);

    localparam int ID_W = clog2_min1(NUM_IRQ);

    irq_state_e         state_q, state_d;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q;
    logic [ID_W-1:0]    id_q, id_d;

    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr;
    logic               enc_found;
    logic [ID_W-1:0]    enc_id;
    logic               ack_fire;
    logic               target_live;

    assign eligible    = pending_q & ~mask_q;
    assign rise        = irq_in & ~irq_q;
    assign ack_fire    = (state_q == REQ) && bus.int_ack;
    assign target_live = eligible[id_q];
    assign clr         = ack_fire ? (NUM_IRQ'(1) << id_q) : '0;

    irq_priority_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_enc (
        .eligible (eligible),
        .found    (enc_found),
        .id       (enc_id)
    );

    // Edge channels are sticky with set beating an ack clear; level channels follow the line
    always_comb begin
        pending_d = (EDGE_MASK & (rise | (pending_q & ~clr))) | (~EDGE_MASK & irq_in);
    end

    // Next state: arbitrate only from IDLE, hold the target through REQ and SERVICE
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (enc_found) begin
                    id_d    = enc_id;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.int_ack) state_d = SERVICE;
                else if (!target_live) state_d = IDLE;
            end
            SERVICE: begin
                if (bus.rti) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and capture registers; reset abandons any request or service in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            irq_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_in;
            pending_q <= pending_d;
            id_q      <= id_d;
            if (mask_we) mask_q <= mask_wdata;
        end
    end

    assign pending        = pending_q;
    assign mask           = mask_q;
    assign bus.int_req    = (state_q == REQ);
    assign bus.in_service = (state_q == SERVICE);
    assign bus.int_id     = id_q;
    assign bus.vec_addr   = VEC_BASE + 16'(VEC_ENTRY_WORDS) * 16'(id_q);

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Parametrised multi-channel interrupt controller. It replaces the single raw interrupt input on the processor top.
- Captures up to NUM_IRQ interrupt lines, which may be edge- or level-triggered per channel, and applies per-channel masking.
- Selects the highest-priority pending request and presents it to the fetch/decode pipeline with a request/acknowledge handshake, together with the vector-table address of the handler.
- Tracks one in-service interrupt (no nesting) until the pipeline signals return-from-interrupt.

Parameters:
- NUM_IRQ, 4, number of interrupt channels (1..16).
- EDGE_MASK, {NUM_IRQ{1'b1}}, per-channel trigger mode: 1 = rising edge, 0 = active-high level.
- VEC_BASE, 16'h0000, data-memory word address of vector entry 0. Each entry is 2 words (32-bit PC, low word first).
- ID_W, derived as max(1, clog2(NUM_IRQ)), width of the interrupt id (localparam).

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous active-low reset (0 = reset).
- irq_in, input, NUM_IRQ, raw interrupt lines, already synchronous to clk.
- mask_we, input, 1, write strobe for mask register.
- mask_wdata, input, NUM_IRQ, new mask value; bit = 1 disables the channel.
- int_ack, input, 1, pipeline accepts the request and starts the INT push sequence.
- rti, input, 1, pipeline has completed return-from-interrupt.
- int_req, output, 1, interrupt request to pipeline.
- int_id, output, ID_W, id of the requested or in-service channel.
- vec_addr, output, 16, VEC_BASE + 2*int_id.
- in_service, output, 1, a handler is active.
- pending, output, NUM_IRQ, pending flags (visible even for masked channels).
- mask, output, NUM_IRQ, current mask register.

Behaviour:
- Reset (reset = 0, asynchronous):
  - irq_q, pending, mask, int_id and state clear to 0.
  - int_req = 0, in_service = 0, vec_addr = VEC_BASE.
  - A reset asserted mid-handshake or mid-service abandons everything; no request survives.
- Edge capture:
  - irq_q <= irq_in every cycle.
  - For an edge channel i, pending[i] sets on a clock edge where irq_in[i] = 1 and irq_q[i] = 0.
  - For a level channel, pending[i] <= irq_in[i] every cycle; it is not sticky.
- Pending clear:
  - For edge channels only, pending[int_id] clears on the cycle int_ack is accepted.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Mask: mask <= mask_wdata on mask_we. The new mask takes effect for arbitration in the following cycle.
- Eligible vector: eligible = pending & ~mask.
- Priority: the lowest index wins, via a fixed combinational priority encoder.
- FSM (registered state: IDLE, REQ, SERVICE):
  - IDLE: if eligible != 0, latch int_id = encoder output, go to REQ. int_req asserts on the next cycle (registered).
  - REQ:
    - int_req = 1; int_id and vec_addr are held stable.
    - The target is not re-arbitrated, even if a higher-priority channel becomes pending.
    - int_ack = 1 moves to SERVICE.
    - If the latched channel becomes masked or non-pending (level line dropped) before the ack, withdraw: int_req drops and the FSM returns to IDLE the next cycle. An ack in that same cycle takes priority and SERVICE is entered.
  - SERVICE: in_service = 1, int_req = 0. New edges keep latching into pending. rti = 1 returns to IDLE, and the next request can issue one cycle later.
- Ignored inputs: int_ack outside REQ, and rti outside SERVICE.
- Latency (edge channel, unmasked, IDLE): edge sampled at clock n, pending visible after n, FSM latches id at n+1, int_req high in cycle n+2.
- vec_addr: computed as VEC_BASE + {int_id, 1'b0}, 16-bit, wraps modulo 2^16.
- Output timing: all outputs are registered or derived only from registers; there is no combinational path from inputs to int_req.

Decomposition:
- Shared package irq_pkg:
  - FSM state enum (IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2).
  - Function clog2_min1 for ID_W.
  - Constant VEC_ENTRY_WORDS = 2.
- Sub-module irq_priority_enc:
  - Parameterised on NUM_IRQ.
  - Outputs found (1) and id (ID_W) for the lowest set bit of eligible.

Test Plan:
- Reset state: hold reset = 0 with irq_in = 4'b1111 -> int_req = 0, pending = 0, vec_addr = 16'h0000. Release reset, with irq_in already high at release and irq_q = 0 -> edge captured, int_req = 1 two cycles later with int_id = 0.
- Single edge: pulse irq_in[2] for one cycle, VEC_BASE = 16'h0040 -> int_req high exactly 2 cycles later, int_id = 2, vec_addr = 16'h0044. int_ack -> pending[2] = 0, in_service = 1. rti -> in_service = 0.
- Priority and hold: irq_in[3] rises, then irq_in[1] rises while in REQ -> int_id stays 3 until ack. After rti, the next request has int_id = 1, vec_addr = VEC_BASE + 2.
- Masking: write mask = 4'b0100, pulse irq_in[2] -> pending[2] = 1, no int_req. Write mask = 0 -> int_req asserts 2 cycles after the write with int_id = 2.
- Level withdraw: EDGE_MASK = 4'b1110, raise irq_in[0], drop it while in REQ without ack -> int_req falls and the FSM returns to IDLE, no SERVICE entry. Raise it again and ack -> pending[0] is not cleared by the ack and follows irq_in.
- Async reset mid-service: assert reset = 0 while in_service = 1 with pending = 4'b1010 -> all outputs clear immediately, without waiting for a clk edge. After release, no request appears until a new edge arrives.
